// File: rtl/iiitb_lifo_stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: op encoding, width helpers and flag bundle.
// Imported by the interface, the storage sub-module and the top.
package lifo_pkg;

    // Op encoding is the concatenation {push, pop}.
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
    } lifo_flags_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 2) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iiitb_lifo_stack_if.sv
// Control/data bundle between the wrapper (master) and the LIFO stack (slave).
// Widths follow the DATA_W/DEPTH parameters of the attached stack.
interface iiitb_lifo_stack_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
);
    localparam int CW = lifo_pkg::cnt_width(DEPTH);

    logic              EN;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] dataIn;
    logic              clr_err;
    logic [DATA_W-1:0] dataOut;
    logic              dout_valid;
    logic              EMPTY;
    logic              FULL;
    logic              ALMOST_FULL;
    logic [CW-1:0]     count;
    logic              OVF;
    logic              UDF;

    modport master (
        output EN, push, pop, dataIn, clr_err,
        input  dataOut, dout_valid, EMPTY, FULL, ALMOST_FULL, count, OVF, UDF
    );

    modport slave (
        input  EN, push, pop, dataIn, clr_err,
        output dataOut, dout_valid, EMPTY, FULL, ALMOST_FULL, count, OVF, UDF
    );

endinterface

// File: rtl/iiitb_lifo_stack_regfile.sv
// Stack storage: DEPTH x DATA_W flop array, one synchronous write port, one combinational read.
// Storage is deliberately unreset; the top never exposes an entry that was not written.
module lifo_regfile
    import lifo_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range addresses exist when DEPTH is not a power of two.
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/iiitb_lifo_stack.sv
// Parametrised LIFO stack with replace-top (push+pop), occupancy flags, sticky errors
// and a registered pop-data path with a one-cycle valid strobe.
module iiitb_lifo_stack
    import lifo_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic               clk,
    input  logic               Rst_n,
    iiitb_lifo_stack_if.slave  bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    logic [CW-1:0]     count_reg, count_next;
    lifo_flags_t       flags_reg, flags_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              dv_reg, dv_next;
    logic              ovf_reg, ovf_next;
    logic              udf_reg, udf_next;

    logic [1:0]        op;
    logic              empty_now;
    logic              full_now;
    logic [CW-1:0]     top_cnt;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     push_idx;
    logic              ovf_evt;
    logic              udf_evt;
    logic              clr;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_rdata;

    assign op        = bus.EN ? {bus.push, bus.pop} : OP_NONE;
    assign clr       = bus.EN & bus.clr_err;
    assign empty_now = (count_reg == '0);
    assign full_now  = (count_reg == CW'(DEPTH));
    assign top_cnt   = empty_now ? '0 : (count_reg - CW'(1));
    assign top_idx   = top_cnt[AW-1:0];
    assign push_idx  = count_reg[AW-1:0];

    always_comb begin
        count_next = count_reg;
        dout_next  = dout_reg;
        dv_next    = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = push_idx;
        ovf_evt    = 1'b0;
        udf_evt    = 1'b0;
        case (op)
            OP_PUSH: begin
                if (full_now) begin
                    ovf_evt = 1'b1;
                end else begin
                    rf_we      = 1'b1;
                    count_next = count_reg + CW'(1);
                end
            end
            OP_POP: begin
                if (empty_now) begin
                    udf_evt = 1'b1;
                end else begin
                    dout_next  = rf_rdata;
                    dv_next    = 1'b1;
                    count_next = count_reg - CW'(1);
                end
            end
            OP_SWAP: begin
                // Replace-top; on an empty stack the pushed word bypasses straight out.
                dv_next = 1'b1;
                if (empty_now) begin
                    dout_next = bus.dataIn;
                end else begin
                    dout_next = rf_rdata;
                    rf_we     = 1'b1;
                    rf_waddr  = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // An error event in the same cycle as clr_err leaves the flag set.
    always_comb begin
        ovf_next = ovf_evt | (ovf_reg & ~clr);
        udf_next = udf_evt | (udf_reg & ~clr);
    end

    always_comb begin
        flags_next.empty       = (count_next == '0);
        flags_next.full        = (count_next == CW'(DEPTH));
        flags_next.almost_full = (count_next >= CW'(AF_THRESH));
    end

    lifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (rf_we & Rst_n),
        .waddr (rf_waddr),
        .wdata (bus.dataIn),
        .raddr (top_idx),
        .rdata (rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            count_reg             <= '0;
            flags_reg.empty       <= 1'b1;
            flags_reg.full        <= 1'b0;
            flags_reg.almost_full <= (AF_THRESH == 0);
            dout_reg              <= '0;
            dv_reg                <= 1'b0;
            ovf_reg               <= 1'b0;
            udf_reg               <= 1'b0;
        end else begin
            count_reg <= count_next;
            flags_reg <= flags_next;
            dout_reg  <= dout_next;
            dv_reg    <= dv_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    assign bus.count       = count_reg;
    assign bus.EMPTY       = flags_reg.empty;
    assign bus.FULL        = flags_reg.full;
    assign bus.ALMOST_FULL = flags_reg.almost_full;
    assign bus.dataOut     = dout_reg;
    assign bus.dout_valid  = dv_reg;
    assign bus.OVF         = ovf_reg;
    assign bus.UDF         = udf_reg;

endmodule
